// File: rtl/xor_stream_decoder.sv
// ---------------------------------------------------------------------------
// xor_stream_decoder
//
// Purpose:
//   Byte-serial keystream descrambler. Each accepted ciphertext byte is XORed
//   with the current state of an 8-bit Galois LFSR, and the result is presented
//   on a registered output stage. The output has 1-cycle latency and supports
//   full throughput. The LFSR advances exactly once per accepted byte, so a
//   stall on either side never skips or repeats a key.
//
// Parameters:
//   TAPS  Galois feedback mask (default 8'h1D, x^8+x^4+x^3+x^2+1)
//   SEED  key substituted when seed_in is zero, so the LFSR cannot lock at 0
//
// Ports:
//   clk        in   clock; all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse, IDLE only: load key from seed_in and enter RUN
//   seed_in    in   [7:0] initial LFSR state, sampled with start
//   stop       in   pulse, RUN only: enter DRAIN
//   in_valid   in   ciphertext byte valid
//   in_ready   out  decoder accepts a byte this cycle (combinational)
//   in_data    in   [7:0] ciphertext byte
//   out_valid  out  plaintext byte valid
//   out_ready  in   consumer takes the plaintext byte
//   out_data   out  [7:0] plaintext byte
//   busy       out  high whenever the FSM is not IDLE
//   byte_count out  [15:0] accepted-byte counter (only with XOR_DEC_COUNT_EN)
//
// Configuration macro:
//   XOR_DEC_COUNT_EN  when defined, adds the byte_count output, cleared on
//                     start and incremented per accept, wrapping silently.
// ---------------------------------------------------------------------------
module xor_stream_decoder #(
  parameter logic [7:0] TAPS = 8'h1D,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  seed_in,
  input  logic        stop,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy
`ifdef XOR_DEC_COUNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       accept;
  logic       pop;
  logic [7:0] lfsr_shift;

`ifdef XOR_DEC_COUNT_EN
  logic [15:0] count_q, count_d;
`endif

  // A new byte may enter whenever the output slot is empty or being emptied
  // in this same cycle, which is what gives full throughput without bubbles.
  assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid_q && out_ready;
  assign lfsr_shift = {lfsr_q[6:0], 1'b0};

  // Next-state logic for the FSM, keystream, output slot and counter.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef XOR_DEC_COUNT_EN
    count_d     = count_q;
`endif

    // An accept overwrites the slot even when it is popped in the same cycle;
    // a pop alone just clears valid and leaves the last data in place.
    if (accept) begin
      out_data_d  = in_data ^ lfsr_q;
      out_valid_d = 1'b1;
      lfsr_d      = lfsr_q[7] ? (lfsr_shift ^ TAPS) : lfsr_shift;
`ifdef XOR_DEC_COUNT_EN
      count_d     = count_q + 16'd1;
`endif
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // No accept can happen in IDLE, so loading the key here never
        // collides with the keystream advance above.
        if (start) begin
          state_d = ST_RUN;
          lfsr_d  = (seed_in == 8'h00) ? SEED : seed_in;
`ifdef XOR_DEC_COUNT_EN
          count_d = 16'd0;
`endif
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave once the slot is empty or its last byte is taken right now.
        if (!out_valid_q || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any pending output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
`ifdef XOR_DEC_COUNT_EN
      count_q     <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef XOR_DEC_COUNT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef XOR_DEC_COUNT_EN
  assign byte_count = count_q;
`endif

endmodule
